// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   rx_state_e          : receiver FSM state encoding
//   UART_RX_FIFO_DEPTH  : receive buffer depth, selected by macro UART_RX_FIFO_EN
//                         (defined -> 4-entry FIFO, undefined -> single holding register)
//   calc_cpb()          : clock cycles per serial bit
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned UART_RX_FIFO_DEPTH = 4;
`else
  localparam int unsigned UART_RX_FIFO_DEPTH = 1;
`endif

  // Clock cycles per bit; callers keep the result >= 8 so mid-bit sampling has margin.
  function automatic int unsigned calc_cpb(int unsigned clk_hz, int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- small synchronous FIFO holding received bytes.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (empties the buffer, clears storage)
//   push_i   : write wdata_i; ignored when full unless pop_i is also high
//   pop_i    : drop the head entry; ignored when empty
//   wdata_i  : byte to store
//   rdata_o  : head entry
//   empty_o  : no entries stored
//   full_o   : Depth entries stored
module uart_rx_fifo #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  // Pointer = {wrap bit, index}; the wrap bit tells full from empty when indices match.
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Index wraps modulo Depth (need not be a power of two); wrap bit toggles on wrap.
  function automatic ptr_t ptr_inc(ptr_t p);
    if (p[AW-1:0] == AW'(Depth - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return p + ptr_t'(1);
  endfunction

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop while full frees the slot the simultaneous push uses.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with receive buffer and sticky error flags.
// Buffer depth: macro UART_RX_FIFO_EN defined -> 4-entry FIFO, undefined -> 1 entry.
//   clk               : clock, rising edge
//   resetn            : asynchronous active-low reset
//   uart_rxd          : serial input, idle high, asynchronous to clk
//   uart_rx_read      : pop the head byte (one per cycle high)
//   uart_rx_clear     : clear frame_err and overrun (a same-cycle set wins)
//   uart_rx_data      : head byte, meaningful while uart_rx_valid is high
//   uart_rx_valid     : buffer not empty
//   uart_rx_frame_err : sticky, a stop bit was sampled low
//   uart_rx_overrun   : sticky, a byte was dropped because the buffer was full
//   uart_rx_busy      : receiver FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 64_000_000,
  parameter int unsigned BIT_RATE = 4_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  input  logic       uart_rx_read,
  input  logic       uart_rx_clear,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic       uart_rx_frame_err,
  output logic       uart_rx_overrun,
  output logic       uart_rx_busy
);

  localparam int unsigned CPB = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int unsigned CW  = $clog2(CPB);
  localparam logic [CW-1:0] HalfLoad = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FullLoad = CW'(CPB - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [1:0]    sync_ok_q;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rx_fall, push, frame_set, overrun_set;
  logic          fifo_empty, fifo_full;

  // Synchroniser. sync_ok_q marks when rxd_sync_q holds a real line sample rather than
  // its reset value; rxd_prev_q stays low until then, so a line that is already low at
  // reset release is never mistaken for a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b0;
      sync_ok_q  <= 2'b00;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= sync_ok_q[1] ? rxd_sync_q : 1'b0;
      sync_ok_q  <= {sync_ok_q[0], 1'b1};
    end
  end

  assign rx_fall = rxd_prev_q & ~rxd_sync_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rxd_sync_q) begin
            state_d = StData;
            cnt_d   = FullLoad;
            bit_d   = '0;
          end else begin
            state_d = StIdle;  // glitch, not a start bit
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rxd_sync_q, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FullLoad;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rxd_sync_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_set = 1'b1;
            state_d   = StBreak;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StBreak: begin
        if (rxd_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign overrun_set = push & fifo_full & ~uart_rx_read;

  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (uart_rx_clear) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set)   frame_err_d = 1'b1;
    if (overrun_set) overrun_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .Depth (UART_RX_FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (push),
    .pop_i   (uart_rx_read),
    .wdata_i (shift_q),
    .rdata_o (uart_rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign uart_rx_valid     = ~fifo_empty;
  assign uart_rx_frame_err = frame_err_q;
  assign uart_rx_overrun   = overrun_q;
  assign uart_rx_busy      = (state_q != StIdle);

endmodule
